epu_dma: RTL and testbench
==========================

# epu_dma

Single-channel AXI master that moves a word-aligned block from system memory into EPU address space. Typical targets are the input, weight, bias and param buffers at 0x5000_0000–0x72FF_FFFF. It sits directly upstream of the EPU slave wrapper on the same AXI bus, so the CPU no longer has to push every word itself. Each chunk is read in an INCR burst of up to 16 beats into a local 16-word buffer, then written out as an equal-length INCR burst. Completion raises a level interrupt.

## Interface
- `AXI_ID`, default 4'h0, constant `arid`/`awid` driven on every request.
- `BURST_MAX`, default 16, maximum beats per burst and local buffer depth (power of two, ≤16).
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_we` in 1: register write strobe from the CPU slave port.
- `cfg_addr` in 4: register byte offset (0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL).
- `cfg_wdata` in 32: register write data.
- `cfg_rdata` out 32: registers are readable at the same offsets. 0xC reads {29'b0, err, busy, dmaint_o}.
- `busy_o` out 1: transfer in progress.
- `dmaint_o` out 1: done interrupt, level, held until cleared.
- AXI read address: `araddr`[32], `arlen`[4], `arsize`[3], `arburst`[2], `arid`[4], `arvalid` (outputs); `arready` (input).
- AXI read data: `rdata`[32], `rresp`[2], `rlast`, `rvalid`, `rid`[4] (inputs); `rready` (output).
- AXI write address: `awaddr`, `awlen`, `awsize`, `awburst`, `awid`, `awvalid` (outputs); `awready` (input).
- AXI write data: `wdata`[32], `wstrb`[4], `wlast`, `wvalid` (outputs); `wready` (input).
- AXI write response: `bresp`[2], `bvalid`, `bid` (inputs); `bready` (output).

## Operation
- **Registers:**
  - SRC and DST take `cfg_wdata[31:0]`.
  - LEN takes `[15:0]`, the word count, 0..65535.
  - CTRL bit0=start, bit1=clear interrupt and err.
  - Writes to SRC, DST and LEN while busy are ignored.
- **Start:**
  - A CTRL write with bit0=1 while idle latches the working copies `cur_src=SRC`, `cur_dst=DST`, `remain=LEN`, then goes to CHK.
  - A start while busy is ignored.
- **States:** IDLE, CHK, AR, R, AW, W, B, DONE.
- **CHK:**
  - If `SRC[5:0]≠0` or `DST[5:0]≠0`: set err, go to DONE. 64-byte alignment keeps every burst inside a 4 KB page.
  - Else if `remain==0`: go to DONE.
  - Else `blen=min(remain,BURST_MAX)`, go to AR.
- **AR:** `arvalid=1`, `araddr=cur_src`, `arlen=blen-1`, `arsize=3'b010`, `arburst=INCR`. Hold until `arready`, then go to R.
- **R:**
  - `rready=1`. Each `rvalid` beat writes `rdata` to `buf[rcnt]` and increments `rcnt`.
  - Any `rresp≠OKAY` sets err; the transfer still completes.
  - The beat with `rlast`, or `rcnt==blen-1`, goes to AW.
  - An `rlast` arriving early (before `blen` beats) sets err and goes to AW. The short burst is still written with `blen` beats; unfilled entries hold stale data.
- **AW:** `awvalid=1`, `awaddr=cur_dst`, same len/size/burst as the read. Hold until `awready`, then go to W.
- **W:**
  - `wvalid=1`, `wdata=buf[wcnt]`, `wstrb=4'hF`, `wlast=(wcnt==blen-1)`.
  - `wcnt` advances only on `wvalid&wready`. The beat with `wlast` goes to B.
- **B:**
  - `bready=1`. On `bvalid`: `bresp≠OKAY` sets err.
  - Then `cur_src+=4*blen`, `cur_dst+=4*blen`, `remain-=blen`.
  - If `remain` is now 0, go to DONE; else recompute `blen` and go to AR.
- **DONE:** set `dmaint_o`, go to IDLE. `dmaint_o` and err stay set until a CTRL bit1 write or reset.
- **Simultaneous CTRL bits:** start and clear in the same write perform the clear first, then the start.
- **Fixed fields:** `arid`/`awid` are always `AXI_ID`. `rid`/`bid` are not checked.
- **Outputs while idle:** all valid/ready outputs are 0 and `busy_o=0`.

## Timing
- **Reset values:** after reset every output is 0. This includes `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `busy_o`, `dmaint_o` and `cfg_rdata` content. All registers reset to 0 and the state returns to IDLE.
- **Reset mid-operation:** the next edge forces IDLE with all valids deasserted. The interrupted AXI transaction is abandoned; the system reset covers the slave side.
- **Start latency:** the cycle after the CTRL write the state is CHK and `busy_o=1`. `arvalid` rises one cycle later.
- **Registered outputs:** all AXI valid/ready outputs are registered state decodes; none depends combinationally on an AXI input.
- **Handshake rules:**
  - `arvalid` and `awvalid` with their address fields stay stable until accepted.
  - `wdata` changes only after a handshake.
- **Zero-wait throughput:** one beat per cycle in R and W.
- **Per-burst overhead:** CHK and DONE cost one cycle each; AR, AW and B cost at least one each.
- **Interrupt timing:** `busy_o` falls in the same cycle `dmaint_o` rises, which is the cycle after DONE.

## Test plan
- **Single short burst:** SRC=0x1000, DST=0x7000_0000, LEN=5, slave with zero wait → one AR with `arlen=4`, one AW with `awlen=4`. Destination equals source; `wlast` is on beat 5; `dmaint_o=1`, err=0.
- **Multi-burst with remainder:** LEN=40 → bursts of 16, 16, 8 (`arlen` 15, 15, 7). DST increments by 0x40 per burst; final `remain=0`.
- **Backpressure:** random `arready`/`awready`/`wready` stalls, plus `rvalid` gaps → address fields and `wdata` stay stable during stalls; data matches; no beat is duplicated or dropped.
- **Error paths:**
  - SRC=0x1004 → no AXI traffic; err=1 and `dmaint_o=1` two cycles after start.
  - `rresp=SLVERR` on one beat → transfer completes with err=1.
- **Edge cases:**
  - LEN=0 → `dmaint_o` set with no AXI traffic.
  - Start written while busy → ignored.
  - CTRL bit1 write → `dmaint_o` and err clear the next cycle.
- **Reset mid-burst:** assert `rst` during W beat 3 → the next cycle has all valids at 0 and `busy_o=0`. A new LEN=1 start then completes normally.

Source files
------------

// File: rtl/epu_dma.sv
// epu_dma: single-channel AXI master that copies a word-aligned block from
// system memory into EPU space in INCR bursts of up to BURST_MAX beats.
// Ports: cfg_* CPU register port; busy_o/dmaint_o status;
//        ar/r/aw/w/b AXI master channels (rid/bid are ignored).
module epu_dma #(
    parameter logic [3:0] AXI_ID    = 4'h0,
    parameter int         BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        busy_o,
    output logic        dmaint_o,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    input  logic [3:0]  rid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [3:0]  awid,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    input  logic [3:0]  bid,
    output logic        bready
);

    localparam int         IW   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [4:0] BMAX = 5'(BURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [31:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [15:0] remain_q, remain_d;
    logic [4:0]  blen_q, blen_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d, int_q, int_d;
    logic [31:0] mem_q [BURST_MAX];

    logic        wr_ctrl;
    logic [4:0]  blen_m1;
    logic [15:0] rem_nxt;
    logic [31:0] step;
    logic        unused_ok;

    function automatic logic [4:0] blen_of(input logic [15:0] r);
        if (r < 16'(BURST_MAX)) return r[4:0];
        return BMAX;
    endfunction

    assign wr_ctrl   = cfg_we && (cfg_addr == 4'hC);
    assign blen_m1   = blen_q - 5'd1;
    assign rem_nxt   = remain_q - {11'b0, blen_q};
    assign step      = {25'b0, blen_q, 2'b00};
    assign unused_ok = ^{rid, bid, blen_m1[4]};

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        remain_d  = remain_q;
        blen_d    = blen_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        int_d     = int_q;

        if (cfg_we && state_q == S_IDLE) begin
            case (cfg_addr)
                4'h0:    src_d = cfg_wdata;
                4'h4:    dst_d = cfg_wdata;
                4'h8:    len_d = cfg_wdata[15:0];
                default: ;
            endcase
        end
        // Clear happens before any start in the same write.
        if (wr_ctrl && cfg_wdata[1]) begin
            err_d = 1'b0;
            int_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr_ctrl && cfg_wdata[0]) begin
                    cur_src_d = src_q;
                    cur_dst_d = dst_q;
                    remain_d  = len_q;
                    state_d   = S_CHK;
                end
            end
            S_CHK: begin
                // 64-byte alignment keeps a 16-beat burst inside one 4 KB page.
                if (cur_src_q[5:0] != 6'd0 || cur_dst_q[5:0] != 6'd0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (remain_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    blen_d  = blen_of(remain_q);
                    cnt_d   = 5'd0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    cnt_d = cnt_q + 5'd1;
                    if (rresp != 2'b00) err_d = 1'b1;
                    if (rlast || cnt_q == blen_m1) begin
                        // Early rlast: still write blen beats, flag it.
                        if (cnt_q != blen_m1) err_d = 1'b1;
                        cnt_d   = 5'd0;
                        state_d = S_AW;
                    end
                end
            end
            S_AW: begin
                if (awready) state_d = S_W;
            end
            S_W: begin
                if (wready) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == blen_m1) state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (bresp != 2'b00) err_d = 1'b1;
                    cur_src_d = cur_src_q + step;
                    cur_dst_d = cur_dst_q + step;
                    remain_d  = rem_nxt;
                    if (rem_nxt == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        blen_d  = blen_of(rem_nxt);
                        cnt_d   = 5'd0;
                        state_d = S_AR;
                    end
                end
            end
            S_DONE: begin
                int_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            remain_q  <= '0;
            blen_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            int_q     <= 1'b0;
            for (int i = 0; i < BURST_MAX; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            remain_q  <= remain_d;
            blen_q    <= blen_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            int_q     <= int_d;
            if (state_q == S_R && rvalid) mem_q[cnt_q[IW-1:0]] <= rdata;
        end
    end

    // Address/control fields are zeroed outside their valid phase.
    assign arvalid  = (state_q == S_AR);
    assign araddr   = arvalid ? cur_src_q : '0;
    assign arlen    = arvalid ? blen_m1[3:0] : '0;
    assign arsize   = arvalid ? 3'b010 : '0;
    assign arburst  = arvalid ? 2'b01 : '0;
    assign arid     = AXI_ID;
    assign rready   = (state_q == S_R);
    assign awvalid  = (state_q == S_AW);
    assign awaddr   = awvalid ? cur_dst_q : '0;
    assign awlen    = awvalid ? blen_m1[3:0] : '0;
    assign awsize   = awvalid ? 3'b010 : '0;
    assign awburst  = awvalid ? 2'b01 : '0;
    assign awid     = AXI_ID;
    assign wvalid   = (state_q == S_W);
    assign wdata    = wvalid ? mem_q[cnt_q[IW-1:0]] : '0;
    assign wstrb    = wvalid ? 4'hF : '0;
    assign wlast    = wvalid && (cnt_q == blen_m1);
    assign bready   = (state_q == S_B);
    assign busy_o   = (state_q != S_IDLE);
    assign dmaint_o = int_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            4'h0:    cfg_rdata = src_q;
            4'h4:    cfg_rdata = dst_q;
            4'h8:    cfg_rdata = {16'b0, len_q};
            4'hC:    cfg_rdata = {29'b0, err_q, busy_o, int_q};
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_epu_dma.sv
// tb_epu_dma: directed bench for epu_dma with a cycle-level AXI slave
// that checks handshake stability, beat counts and copied data.
module tb_epu_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        busy_o, dmaint_o;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arid, awid, rid, bid, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready;

    int tests = 0;
    int fails = 0;

    int          ar_n, aw_n, w_n;
    logic [31:0] ar_addr_log [8];
    logic [31:0] aw_addr_log [8];
    logic [3:0]  ar_len_log  [8];
    logic [3:0]  aw_len_log  [8];
    logic [31:0] rv;

    always #5 clk = ~clk;

    epu_dma dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .busy_o(busy_o), .dmaint_o(dmaint_o),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rid(rid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid), .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] srcword(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    task automatic idle_slave();
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rlast = 0; rresp = 0; rdata = 0; rid = 0;
        bvalid = 0; bresp = 0; bid = 0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 0; cfg_wdata = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    // Slave loop: decide inputs at each negedge, account handshakes that
    // the following posedge will complete.
    task automatic serve(input bit stall, input int err_beat,
                         input int rst_wbeat, input int max_cyc);
        bit          r_act, b_pend, p_arv, p_awv, p_wv;
        logic [31:0] r_addr, w_src, p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_arlen, p_awlen;
        int          r_len, r_beat, w_len, w_beat, rtot, cyc;
        r_act = 0; b_pend = 0; p_arv = 0; p_awv = 0; p_wv = 0;
        r_addr = 0; w_src = 0; p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        p_arlen = 0; p_awlen = 0;
        r_len = 0; r_beat = 0; w_len = 0; w_beat = 0; rtot = 0; cyc = 0;
        ar_n = 0; aw_n = 0; w_n = 0;
        while (!dmaint_o && cyc < max_cyc) begin
            if (p_arv) begin
                chk("ar_hold_valid", arvalid, 1);
                chk("ar_hold_addr", araddr, p_araddr);
                chk("ar_hold_len", arlen, p_arlen);
            end
            if (p_awv) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, p_awaddr);
                chk("aw_hold_len", awlen, p_awlen);
            end
            if (p_wv) chk("w_hold_data", wdata, p_wdata);

            if (rst_wbeat >= 0 && wvalid && w_n == rst_wbeat) begin
                rst = 1;
                idle_slave();
                chk("rst_at_wbeat", w_n, rst_wbeat);
                return;
            end

            arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_act && (!stall || $urandom_range(0, 2) != 0)) begin
                rvalid = 1;
                rdata  = srcword(r_addr + 32'(4 * r_beat));
                rlast  = (r_beat == r_len - 1);
                rresp  = (rtot == err_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
            end
            bvalid = b_pend;

            if (arvalid && arready) begin
                if (ar_n < 8) begin
                    ar_addr_log[ar_n] = araddr;
                    ar_len_log[ar_n]  = arlen;
                end
                ar_n++;
                r_act = 1; r_addr = araddr; w_src = araddr;
                r_len = int'(arlen) + 1; r_beat = 0;
            end
            if (rvalid && rready) begin
                rtot++; r_beat++;
                if (rlast) r_act = 0;
            end
            if (awvalid && awready) begin
                if (aw_n < 8) begin
                    aw_addr_log[aw_n] = awaddr;
                    aw_len_log[aw_n]  = awlen;
                end
                aw_n++;
                w_len = int'(awlen) + 1; w_beat = 0;
            end
            if (wvalid && wready) begin
                chk("w_data", wdata, srcword(w_src + 32'(4 * w_beat)));
                chk("w_last", wlast, (w_beat == w_len - 1));
                w_beat++; w_n++;
                if (w_beat == w_len) b_pend = 1;
            end
            if (bvalid && bready) b_pend = 0;

            p_arv = arvalid && !arready;
            p_araddr = araddr; p_arlen = arlen;
            p_awv = awvalid && !awready;
            p_awaddr = awaddr; p_awlen = awlen;
            p_wv = wvalid && !wready;
            p_wdata = wdata;
            @(negedge clk);
            cyc++;
        end
        idle_slave();
        chk("serve_done", dmaint_o, 1);
        chk("irq_busy_low", busy_o, 0);
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l);
        cfg_write(4'h0, s);
        cfg_write(4'h4, d);
        cfg_write(4'h8, {16'b0, l});
    endtask

    initial begin
        rst = 1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        idle_slave();
        repeat (3) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_int", dmaint_o, 0);
        chk("rst_araddr", araddr, 0);
        rst = 0;
        @(negedge clk);
        rd(4'h0, rv); chk("rst_src", rv, 0);
        rd(4'hC, rv); chk("rst_ctrl", rv, 0);

        // Single short burst
        setup(32'h0000_1000, 32'h7000_0000, 16'd5);
        rd(4'h0, rv); chk("src_rb", rv, 32'h1000);
        rd(4'h8, rv); chk("len_rb", rv, 5);
        cfg_write(4'hC, 32'h1);
        chk("start_busy", busy_o, 1);
        chk("start_chk_noar", arvalid, 0);
        @(negedge clk);
        chk("ar_rise", arvalid, 1);
        chk("ar_addr", araddr, 32'h1000);
        chk("ar_len", arlen, 4);
        chk("ar_size", arsize, 3'b010);
        chk("ar_burst", arburst, 2'b01);
        chk("ar_id", arid, 0);
        serve(0, -1, -1, 500);
        chk("t1_ar_n", ar_n, 1);
        chk("t1_arlen", ar_len_log[0], 4);
        chk("t1_aw_n", aw_n, 1);
        chk("t1_awlen", aw_len_log[0], 4);
        chk("t1_awaddr", aw_addr_log[0], 32'h7000_0000);
        chk("t1_w_n", w_n, 5);
        rd(4'hC, rv); chk("t1_status", rv, 32'h1);

        // Clear interrupt
        cfg_write(4'hC, 32'h2);
        chk("clr_int", dmaint_o, 0);
        rd(4'hC, rv); chk("clr_status", rv, 0);

        // Multi-burst with remainder
        setup(32'h0000_2000, 32'h5000_0040, 16'd40);
        cfg_write(4'hC, 32'h1);
        serve(0, -1, -1, 1000);
        chk("mb_ar_n", ar_n, 3);
        chk("mb_arlen0", ar_len_log[0], 15);
        chk("mb_arlen1", ar_len_log[1], 15);
        chk("mb_arlen2", ar_len_log[2], 7);
        chk("mb_araddr1", ar_addr_log[1], 32'h2040);
        chk("mb_araddr2", ar_addr_log[2], 32'h2080);
        chk("mb_awaddr1", aw_addr_log[1], 32'h5000_0080);
        chk("mb_awaddr2", aw_addr_log[2], 32'h5000_00C0);
        chk("mb_awlen2", aw_len_log[2], 7);
        chk("mb_w_n", w_n, 40);
        rd(4'hC, rv); chk("mb_status", rv, 32'h1);
        cfg_write(4'hC, 32'h2);

        // Backpressure on every channel
        setup(32'h0000_3000, 32'h6000_0000, 16'd20);
        cfg_write(4'hC, 32'h1);
        serve(1, -1, -1, 2000);
        chk("bp_ar_n", ar_n, 2);
        chk("bp_arlen1", ar_len_log[1], 3);
        chk("bp_awaddr1", aw_addr_log[1], 32'h6000_0040);
        chk("bp_w_n", w_n, 20);
        rd(4'hC, rv); chk("bp_status", rv, 32'h1);
        cfg_write(4'hC, 32'h2);

        // Misaligned source
        setup(32'h0000_1004, 32'h7000_0000, 16'd4);
        cfg_write(4'hC, 32'h1);
        chk("mis_busy", busy_o, 1);
        @(negedge clk);
        chk("mis_noar1", arvalid, 0);
        chk("mis_int_early", dmaint_o, 0);
        @(negedge clk);
        chk("mis_noar2", arvalid, 0);
        chk("mis_int", dmaint_o, 1);
        chk("mis_busy_low", busy_o, 0);
        rd(4'hC, rv); chk("mis_status", rv, 32'h5);
        cfg_write(4'hC, 32'h2);
        rd(4'hC, rv); chk("mis_clr", rv, 0);

        // SLVERR on read beat 2
        setup(32'h0000_1000, 32'h7000_0000, 16'd5);
        cfg_write(4'hC, 32'h1);
        serve(0, 2, -1, 500);
        chk("se_w_n", w_n, 5);
        rd(4'hC, rv); chk("se_status", rv, 32'h5);
        cfg_write(4'hC, 32'h2);

        // LEN=0
        cfg_write(4'h8, 32'h0);
        cfg_write(4'hC, 32'h1);
        @(negedge clk);
        chk("l0_noar", arvalid, 0);
        @(negedge clk);
        chk("l0_int", dmaint_o, 1);
        rd(4'hC, rv); chk("l0_status", rv, 32'h1);

        // Clear and start in one write
        cfg_write(4'h8, 32'h1);
        cfg_write(4'hC, 32'h3);
        chk("cs_int_clr", dmaint_o, 0);
        chk("cs_busy", busy_o, 1);
        serve(0, -1, -1, 500);
        chk("cs_w_n", w_n, 1);
        rd(4'hC, rv); chk("cs_status", rv, 32'h1);
        cfg_write(4'hC, 32'h2);

        // Start and register writes while busy are ignored
        cfg_write(4'h8, 32'h5);
        cfg_write(4'hC, 32'h1);
        cfg_write(4'h0, 32'h9000);
        cfg_write(4'h8, 32'h2);
        cfg_write(4'hC, 32'h1);
        serve(0, -1, -1, 500);
        chk("bz_ar_n", ar_n, 1);
        chk("bz_araddr", ar_addr_log[0], 32'h1000);
        chk("bz_arlen", ar_len_log[0], 4);
        chk("bz_w_n", w_n, 5);
        rd(4'h0, rv); chk("bz_src", rv, 32'h1000);
        rd(4'h8, rv); chk("bz_len", rv, 5);
        cfg_write(4'hC, 32'h2);

        // Reset during W beat 3
        cfg_write(4'h8, 32'd16);
        cfg_write(4'hC, 32'h1);
        serve(0, -1, 2, 500);
        @(negedge clk);
        chk("mr_arvalid", arvalid, 0);
        chk("mr_awvalid", awvalid, 0);
        chk("mr_wvalid", wvalid, 0);
        chk("mr_rready", rready, 0);
        chk("mr_bready", bready, 0);
        chk("mr_busy", busy_o, 0);
        rd(4'h0, rv); chk("mr_src", rv, 0);
        rst = 0;
        @(negedge clk);
        setup(32'h0000_1000, 32'h7000_0000, 16'd1);
        cfg_write(4'hC, 32'h1);
        serve(0, -1, -1, 500);
        chk("mr2_ar_n", ar_n, 1);
        chk("mr2_arlen", ar_len_log[0], 0);
        chk("mr2_w_n", w_n, 1);
        rd(4'hC, rv); chk("mr2_status", rv, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
